// File: rtl/pong_top.sv
// pong_top: two-player LED ping-pong game.
// A single lit LED (the ball) travels across LED[15:0]. The left player (SW[15])
// and the right player (SW[0]) return it by flipping their switch while the ball
// sits on their end LED. Scores are shown on two digits of the 7-segment display.
// The first player to reach WIN points wins.
//
// Ports:
//   clk    - system clock
//   resetn - synchronous reset, asserted when 1 (historic name)
//   SW     - switches; only SW[15] (left) and SW[0] (right) are used; asynchronous
//   LED    - ball position, or the game-over pattern (1 = lit)
//   DP     - decimal point, active-low, held off
//   AN     - digit anodes, active-low
//   C      - segments {g,f,e,d,c,b,a}, active-low
module pong_top #(
  parameter int unsigned TICK_DIV = 12_500_000,
  parameter int unsigned SCAN_DIV = 50_000,
  parameter int unsigned WIN      = 9
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] SW,
  output logic [15:0] LED,
  output logic        DP,
  output logic [7:0]  AN,
  output logic [6:0]  C
);

  localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned ScanW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [TickW-1:0] TickMax  = TickW'(TICK_DIV - 1);
  localparam logic [ScanW-1:0] ScanMax  = ScanW'(SCAN_DIV - 1);
  localparam logic [3:0]       WinScore = 4'(WIN);

  typedef enum logic [1:0] {StServe, StFly, StOver} state_e;

  function automatic logic [6:0] seg(input logic [3:0] n);
    case (n)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = 7'h7F;
    endcase
  endfunction

  // Switch synchronizers. Left unreset on purpose: they keep tracking the pins
  // during reset, so a switch left up through reset does not read as a toggle.
  logic [1:0] l_sync, r_sync;
  logic       l_prev, r_prev;
  logic       tog_l, tog_r;

  always_ff @(posedge clk) begin
    l_sync <= {l_sync[0], SW[15]};
    r_sync <= {r_sync[0], SW[0]};
    l_prev <= l_sync[1];
    r_prev <= r_sync[1];
  end

  assign tog_l = l_sync[1] ^ l_prev;
  assign tog_r = r_sync[1] ^ r_prev;

  logic unused_sw;
  assign unused_sw = ^SW[14:1];

  // Game state
  state_e           state;
  logic             server_r;  // 1 = right player serves
  logic [3:0]       pos;
  logic             dir;       // 1 = moving toward pos 15
  logic             hit;
  logic [3:0]       score_l, score_r;
  logic [TickW-1:0] tick_cnt;

  logic [3:0] recv_end, pos_step, pos_back, next_l, next_r;
  logic       recv_tog;

  always_comb begin
    recv_end = dir ? 4'd15 : 4'd0;
    recv_tog = dir ? tog_l : tog_r;
    pos_step = dir ? pos + 4'd1 : pos - 4'd1;
    pos_back = dir ? pos - 4'd1 : pos + 4'd1;
    next_l   = score_l + 4'd1;
    next_r   = score_r + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state    <= StServe;
      server_r <= 1'b0;
      pos      <= 4'd15;
      dir      <= 1'b0;
      hit      <= 1'b0;
      score_l  <= 4'd0;
      score_r  <= 4'd0;
      tick_cnt <= '0;
      LED      <= 16'h8000;
    end else begin
      unique case (state)
        StServe: begin
          tick_cnt <= '0;
          if ((!server_r && tog_l) || (server_r && tog_r)) begin
            dir   <= server_r;  // away from the server
            state <= StFly;
          end
        end
        StFly: begin
          if (tick_cnt == TickMax) begin
            // Tick wins over a coincident toggle: decision uses the old hit.
            tick_cnt <= '0;
            hit      <= 1'b0;
            if (pos != recv_end) begin
              pos <= pos_step;
              LED <= 16'd1 << pos_step;
            end else if (hit) begin
              dir <= ~dir;
              pos <= pos_back;
              LED <= 16'd1 << pos_back;
            end else if (!dir) begin
              // Right missed: left scores, right serves from where the ball sits.
              score_l  <= next_l;
              server_r <= 1'b1;
              if (next_l == WinScore) begin
                state <= StOver;
                LED   <= 16'hFF00;
              end else begin
                state <= StServe;
              end
            end else begin
              score_r  <= next_r;
              server_r <= 1'b0;
              if (next_r == WinScore) begin
                state <= StOver;
                LED   <= 16'h00FF;
              end else begin
                state <= StServe;
              end
            end
          end else begin
            tick_cnt <= tick_cnt + TickW'(1);
            if (recv_tog && pos == recv_end) begin
              hit <= 1'b1;
            end
          end
        end
        StOver: begin
          tick_cnt <= '0;
        end
        default: begin
          state <= StServe;
        end
      endcase
    end
  end

  // Display scan: slot 0 = left score on the leftmost digit, slot 1 = right score
  // on the rightmost digit.
  logic [ScanW-1:0] scan_cnt;
  logic             slot;

  always_ff @(posedge clk) begin
    if (resetn) begin
      scan_cnt <= '0;
      slot     <= 1'b0;
      AN       <= 8'h7F;
      C        <= 7'h40;
    end else if (scan_cnt == ScanMax) begin
      scan_cnt <= '0;
      slot     <= ~slot;
      AN       <= slot ? 8'h7F : 8'hFE;
      C        <= slot ? seg(score_l) : seg(score_r);
    end else begin
      scan_cnt <= scan_cnt + ScanW'(1);
      C        <= slot ? seg(score_r) : seg(score_l);
    end
  end

  assign DP = 1'b1;

endmodule

// File: tb/tb_pong_top.sv
// Directed bench for pong_top with short tick/scan dividers.
module tb_pong_top;

  logic        clk;
  logic        resetn;
  logic [15:0] sw;
  logic [15:0] led;
  logic        dp;
  logic [7:0]  an;
  logic [6:0]  c;

  int n_checks = 0;
  int n_fails  = 0;

  pong_top #(
    .TICK_DIV(4),
    .SCAN_DIV(2),
    .WIN     (9)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .SW    (sw),
    .LED   (led),
    .DP    (dp),
    .AN    (an),
    .C     (c)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_exp(input int n);
    case (n)
      0:       seg_exp = 7'h40;
      1:       seg_exp = 7'h79;
      2:       seg_exp = 7'h24;
      3:       seg_exp = 7'h30;
      4:       seg_exp = 7'h19;
      5:       seg_exp = 7'h12;
      6:       seg_exp = 7'h02;
      7:       seg_exp = 7'h78;
      8:       seg_exp = 7'h00;
      9:       seg_exp = 7'h10;
      default: seg_exp = 7'h7F;
    endcase
  endfunction

  // Advance n clocks; outputs are then sampled 1 ns after the last edge.
  task automatic step_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic flip(input int idx);
    sw[idx] = ~sw[idx];
  endtask

  task automatic wait_led(input string tag, input logic [15:0] v, input int max,
                          output int cycles);
    cycles = 0;
    while (led !== v && cycles < max) begin
      step_clk(1);
      cycles++;
    end
    check(tag, led, {16'h0, v});
  endtask

  task automatic check_disp(input int l, input int r);
    logic [7:0] an_h [4];
    for (int i = 0; i < 4; i++) begin
      step_clk(1);
      an_h[i] = an;
      check("disp_an_valid", (an == 8'h7F || an == 8'hFE), 1);
      check("disp_c", c, (an == 8'h7F) ? seg_exp(l) : seg_exp(r));
      check("disp_dp", dp, 1);
    end
    check("disp_alt", (an_h[0] != an_h[2]) && (an_h[1] != an_h[3]), 1);
  endtask

  // Right serves, left returns, right misses: left gains one point.
  task automatic point_left();
    int cyc;
    flip(0);
    wait_led("pt_reach_l", 16'h8000, 120, cyc);
    flip(15);
    wait_led("pt_reach_r", 16'h0001, 120, cyc);
    step_clk(4);
  endtask

  initial begin
    int cyc;
    sw     = 16'($urandom);
    resetn = 1'b1;

    // Reset with arbitrary switch positions.
    step_clk(5);
    resetn = 1'b0;
    check("rst_led", led, 32'h8000);
    check("rst_an", an, 32'h7F);
    check("rst_c", c, 32'h40);
    check("rst_dp", dp, 1);

    // Scan phase straight after reset: slot 0 for two clocks, then slot 1.
    step_clk(1); check("scan_e1", an, 32'h7F);
    step_clk(1); check("scan_e2", an, 32'hFE);
    check("scan_e2_c", c, 32'h40);
    step_clk(1); check("scan_e3", an, 32'hFE);
    step_clk(1); check("scan_e4", an, 32'h7F);

    // Left serves.
    flip(15);
    wait_led("serve_step", 16'h4000, 20, cyc);
    check("serve_lat", (cyc >= 6 && cyc <= 8), 1);
    step_clk(3); check("hold_3clk", led, 32'h4000);
    step_clk(1); check("step_4clk", led, 32'h2000);
    for (int k = 12; k >= 0; k--) begin
      step_clk(4);
      check("fly_r", led, 32'(16'd1 << k));
    end

    // Right returns at its end; a later toggle mid-court changes nothing.
    flip(0);
    step_clk(4); check("ret_r", led, 32'h0002);
    step_clk(4); check("ret_r2", led, 32'h0004);
    flip(0);
    for (int k = 3; k <= 15; k++) begin
      step_clk(4);
      check("fly_l", led, 32'(16'd1 << k));
    end

    // Left returns, then the right player misses.
    flip(15);
    step_clk(4); check("ret_l", led, 32'h4000);
    for (int k = 13; k >= 0; k--) begin
      step_clk(4);
      check("fly_r2", led, 32'(16'd1 << k));
    end
    step_clk(4); check("miss_led", led, 32'h0001);
    check_disp(1, 0);

    // Right now serves; a left toggle must not launch the ball.
    flip(15);
    step_clk(12); check("no_serve_l", led, 32'h0001);

    // Left takes the remaining eight points.
    for (int p = 2; p <= 9; p++) begin
      point_left();
    end
    check("over_led", led, 32'hFF00);
    check_disp(9, 0);

    flip(0);
    flip(15);
    step_clk(24); check("over_hold", led, 32'hFF00);
    flip(0);
    step_clk(24); check("over_hold2", led, 32'hFF00);

    // Reset from game over.
    resetn = 1'b1;
    step_clk(1);
    resetn = 1'b0;
    check("rst2_led", led, 32'h8000);
    check("rst2_an", an, 32'h7F);
    check("rst2_c", c, 32'h40);
    check("rst2_dp", dp, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fails);
    $finish;
  end

  // Hard stop in case the sequence above stalls.
  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
